// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } hold_ent_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {inst,pc} holding register for a response that decode could not take.
// Latency: 1 cycle load-to-full; clear wins over load; no backpressure of its own.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic      Clk,
    input  logic      Clrn,
    input  logic      load_i,
    input  logic      clear_i,
    input  hold_ent_t ent_i,
    output hold_ent_t ent_o,
    output logic      full_o
);

    hold_ent_t ent_q;
    logic      full_q;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            ent_q  <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            ent_q  <= ent_i;
            full_q <= 1'b1;
        end
    end

    assign ent_o  = ent_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem req/ready, feeds IF/ID (optional FETCH_PERF_EN counters).
// Latency: memory latency + 1 cycle to if_valid; redirect flushes on the next edge.
// Backpressure: decode stall parks one response in the hold buffer and pauses requests.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clrn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic        if_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  ifpc_q, ifpc_d;
    logic [31:0]  ifpc4_q, ifpc4_d;
    logic         valid_q, valid_d;

    logic         buf_load, buf_clear, buf_full;
    hold_ent_t    buf_in, buf_out;

    logic         xfer;
    logic         slot_free;
    logic         keep_xfer;
    logic [31:0]  redir_tgt;

    // Request is gated by reset so nothing is presented to memory while Clrn is low.
    assign imem_req  = Clrn && (state_q != HOLD);
    assign imem_addr = pc_q;
    assign xfer      = imem_req && imem_ready;
    assign slot_free = !valid_q || !stall;
    assign redir_tgt = align_pc(redirect_pc);
    assign buf_in    = '{inst: imem_rdata, pc: pc_q};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        inst_d    = inst_q;
        ifpc_d    = ifpc_q;
        ifpc4_d   = ifpc4_q;
        valid_d   = valid_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        keep_xfer = 1'b0;

        if (valid_q && !stall) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end

        if (redirect) begin
            valid_d   = 1'b0;
            inst_d    = NOP_INST;
            buf_clear = 1'b1;
        end

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (xfer) begin
                        pc_d = redir_tgt;
                    end else begin
                        tgt_d   = redir_tgt;
                        state_d = DRAIN;
                    end
                end else if (xfer) begin
                    keep_xfer = 1'b1;
                    pc_d      = pc_q + PC_INC;
                    if (slot_free) begin
                        inst_d  = imem_rdata;
                        ifpc_d  = pc_q;
                        ifpc4_d = pc_q + PC_INC;
                        valid_d = 1'b1;
                    end else begin
                        pc_d     = pc_q;
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redir_tgt;
                    state_d = FETCH;
                end else if (!stall) begin
                    inst_d    = buf_out.inst;
                    ifpc_d    = buf_out.pc;
                    ifpc4_d   = buf_out.pc + PC_INC;
                    valid_d   = buf_full;
                    buf_clear = 1'b1;
                    pc_d      = pc_q + PC_INC;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                // The outstanding response is thrown away; the newest target wins.
                if (xfer) begin
                    pc_d    = redirect ? redir_tgt : tgt_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    tgt_d = redir_tgt;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            inst_q  <= NOP_INST;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
        end
    end

    fetch_hold_buf u_hold_buf (
        .Clk     (Clk),
        .Clrn    (Clrn),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .ent_i   (buf_in),
        .ent_o   (buf_out),
        .full_o  (buf_full)
    );

    assign if_inst  = inst_q;
    assign if_pc    = ifpc_q;
    assign if_pc4   = ifpc4_q;
    assign if_valid = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (keep_xfer) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (valid_q && stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`else
    logic unused_keep;
    assign unused_keep = keep_xfer;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-configurable memory model, plus a second
// instance with RESET_PC at the top of the address space to cover PC wrap.
module tb_fetch_stage;

    logic        Clk;
    logic        Clrn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_inst, if_pc, if_pc4;
    logic        if_valid;

    logic        req2;
    logic [31:0] addr2, rdata2, inst2, pc2, pc4_2;
    logic        valid2;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          lat = 0;
    int          wait_cnt = 0;
    logic        draining = 1'b0;
    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_addr = '0;

    assign imem_rdata = imem_ready ? ~imem_addr : 32'h0;
    assign rdata2     = req2 ? ~addr2 : 32'h0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clk         (Clk),
        .Clrn        (Clrn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall),
`endif
        .if_valid    (if_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk         (Clk),
        .Clrn        (Clrn),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_ready  (req2),
        .imem_rdata  (rdata2),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .if_inst     (inst2),
        .if_pc       (pc2),
        .if_pc4      (pc4_2),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched2),
        .perf_stall  (perf_stall2),
`endif
        .if_valid    (valid2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge with inputs already applied.
    task automatic tick();
        logic xfer;
        exp_t e;
        imem_ready = imem_req && (wait_cnt >= lat);
        #1;
        xfer = imem_req && imem_ready;
        if (Clrn) begin
            if (prev_pending) begin
                chk("req_held", imem_req, 1);
                chk("addr_held", imem_addr, prev_addr);
            end else if (imem_req) begin
                chk("req_addr", imem_addr, exp_addr);
            end
            if (redirect) begin
                sb.delete();
                exp_addr = {redirect_pc[31:2], 2'b00};
                if (imem_req && !imem_ready) draining = 1'b1;
            end else if (if_valid && !stall) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_valid", if_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_inst", if_inst, e.inst);
                    chk("sb_pc", if_pc, e.pc);
                    chk("sb_pc4", if_pc4, e.pc + 32'd4);
                end
            end
            if (xfer) begin
                if (redirect || draining) begin
                    draining = 1'b0;
                end else begin
                    sb.push_back('{inst: ~imem_addr, pc: imem_addr});
                    exp_addr = imem_addr + 32'd4;
                end
            end
            prev_pending = imem_req && !imem_ready;
            prev_addr    = imem_addr;
        end
        if (xfer) wait_cnt = 0;
        else if (imem_req) wait_cnt++;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic model_reset();
        sb.delete();
        draining     = 1'b0;
        prev_pending = 1'b0;
        exp_addr     = 32'h0;
        wait_cnt     = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        Clrn        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        repeat (3) @(negedge Clk);

        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_inst", if_inst, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_pc4", if_pc4, 0);
        chk("rst_req_wrap", req2, 0);

        // Zero-wait memory, no stall.
        Clrn = 1'b1;
        model_reset();
        #1;
        chk("s1_req0", imem_req, 1);
        chk("s1_addr0", imem_addr, 32'h0);
        chk("s5_addr0", addr2, 32'hFFFF_FFFC);
        tick();
        chk("s1_addr1", imem_addr, 32'h4);
        chk("s1_ifpc0", if_pc, 32'h0);
        chk("s1_ifpc4_0", if_pc4, 32'h4);
        chk("s5_addr1", addr2, 32'h0);
        chk("s5_ifpc", pc2, 32'hFFFF_FFFC);
        chk("s5_ifpc4", pc4_2, 32'h0);
        chk("s5_inst", inst2, 32'h0000_0003);
        tick();
        chk("s1_addr2", imem_addr, 32'h8);
        chk("s1_ifpc1", if_pc, 32'h4);
        chk("s1_ifpc4_1", if_pc4, 32'h8);
        tick();
        chk("s1_ifpc2", if_pc, 32'h8);
`ifdef FETCH_PERF_EN
        chk("s1_perf_fetched", perf_fetched, 32'd3);
        chk("s1_perf_stall", perf_stall, 32'd0);
`endif

        // Stall for three cycles across the 0x10 response.
        tick();
        chk("s2_addr10", imem_addr, 32'h10);
        chk("s2_ifpc_c", if_pc, 32'hC);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_hold_req", imem_req, 0);
            chk("s2_hold_ifpc", if_pc, 32'hC);
            chk("s2_hold_valid", if_valid, 1);
        end
        stall = 1'b0;
        tick();
        chk("s2_ifpc10", if_pc, 32'h10);
        chk("s2_addr14", imem_addr, 32'h14);
        chk("s2_req", imem_req, 1);
`ifdef FETCH_PERF_EN
        chk("s2_perf_stall", perf_stall, 32'd3);
`endif

        // Latency 3, redirect one cycle after the 0x20 request is issued.
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req && imem_addr == 32'h20 && !prev_pending) found = 1'b1;
            else tick();
        end
        chk("s3_find20", found, 1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect    = 1'b0;
        chk("s3_drain_req", imem_req, 1);
        chk("s3_drain_addr", imem_addr, 32'h20);
        chk("s3_flush_valid", if_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && imem_addr == 32'h100) found = 1'b1;
            else tick();
        end
        chk("s3_find100", found, 1);
        chk("s3_discard_valid", if_valid, 0);
        chk("s3_discard_inst", if_inst, 0);

        // Zero-wait again: redirect coincident with ready, then with stall.
        lat = 0;
        repeat (4) tick();
        chk("s4_pre_valid", if_valid, 1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect    = 1'b0;
        chk("s4_drop_valid", if_valid, 0);
        chk("s4_tgt_addr", imem_addr, 32'h300);
        repeat (2) tick();
        chk("s4_pre2_valid", if_valid, 1);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0202;
        tick();
        redirect    = 1'b0;
        chk("s4_stall_flush", if_valid, 0);
        chk("s4_stall_addr", imem_addr, 32'h200);
        stall = 1'b0;
        repeat (3) tick();
        chk("s4_resume_pc", if_pc, 32'h208);

        // Reset in the middle of HOLD.
        stall = 1'b1;
        tick();
        chk("s6_hold_req", imem_req, 0);
        #2;
        Clrn = 1'b0;
        #1;
        chk("s6_rst_req", imem_req, 0);
        chk("s6_rst_valid", if_valid, 0);
        chk("s6_rst_inst", if_inst, 0);
        chk("s6_rst_pc", if_pc, 0);
        chk("s6_rst_pc4", if_pc4, 0);
`ifdef FETCH_PERF_EN
        chk("s6_rst_perf_fetched", perf_fetched, 0);
        chk("s6_rst_perf_stall", perf_stall, 0);
`endif
        stall = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Clrn = 1'b1;
        model_reset();
        #1;
        chk("s6_restart_addr", imem_addr, 32'h0);
        tick();
        chk("s6_restart_ifpc", if_pc, 32'h0);
        chk("s6_restart_valid", if_valid, 1);
        repeat (2) tick();
`ifdef FETCH_PERF_EN
        chk("s6_perf_fetched", perf_fetched, 32'd3);
`endif
        repeat (2) tick();
        chk("s6_final_ifpc", if_pc, 32'h10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the PC and issues requests to instruction memory with a variable-latency req/ready handshake. It presents instr/pc/valid to the decode stage and honours decode stall and branch/jump redirect. A one-entry hold buffer absorbs a response that arrives while decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
Clk  in  1  clock, all state updates on posedge.
Clrn  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request valid.
imem_addr  out  32  word-aligned fetch address; held stable while imem_req=1 and imem_ready=0.
imem_ready  in  1  response valid this cycle; transfer = imem_req & imem_ready.
imem_rdata  in  32  instruction word; valid only when imem_ready=1.
stall  in  1  decode cannot accept a new instruction this cycle.
redirect  in  1  taken branch/jump; has priority over stall.
redirect_pc  in  32  target address; bits [1:0] ignored and forced to 00.
if_inst  out  32  registered instruction to decode.
if_pc  out  32  registered PC of if_inst.
if_pc4  out  32  registered if_pc+4, modulo 2^32.
if_valid  out  1  if_inst holds a real instruction.

Behaviour:
- Reset (Clrn=0, async): pc=RESET_PC, state=FETCH, hold buffer empty, if_inst=0, if_pc=0, if_pc4=0, if_valid=0. imem_req=0 while Clrn=0.
- The first request is issued in the first cycle after Clrn rises.
- Consume rule: decode consumes the current output when if_valid & !stall. The output slot is free when !if_valid | !stall.
- Protocol: once imem_req rises, imem_req and imem_addr stay constant until imem_ready. A request is never withdrawn.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
    - ready & slot free: load outputs from the response (if_pc=pc, if_pc4=pc+4, if_valid=1); pc+=4; stay in FETCH. Latency from request to if_valid is the memory latency plus one cycle.
    - ready & slot not free: write the response into the hold buffer; go to HOLD.
    - no ready: stay in FETCH.
  - HOLD: imem_req=0. When !stall: move the buffer to the outputs; pc+=4; go to FETCH.
  - DRAIN: imem_req=1 at the old address. On ready: discard rdata, pc=target, go to FETCH.
- Bubble: if the current output is consumed and no new instruction is loaded, then if_valid<=0 and if_inst<=0.
- Redirect (any state, overrides stall):
  - if_valid<=0 and the hold buffer is cleared on the next edge.
  - Target register = {redirect_pc[31:2],2'b00}.
  - In FETCH with ready in the same cycle: drop the response, pc=target, stay in FETCH.
  - In FETCH without ready: go to DRAIN.
  - In HOLD: pc=target, go to FETCH.
  - In DRAIN: update the target (last redirect wins) and stay in DRAIN.
- Stall alone never alters pc, the outputs, or the buffer contents.
- PC wrap: 32'hFFFF_FFFC + 4 = 0 with no flag.
- Reset asserted mid-transaction: state returns to reset values immediately. The memory side must tolerate the dropped request.

Optional Feature:
FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_stall[31:0], both reset to 0.
  - perf_fetched increments on every non-discarded transfer.
  - perf_stall increments on every cycle with if_valid & stall.
  - Both wrap at 2^32.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - state encoding FETCH=2'd0, HOLD=2'd1, DRAIN=2'd2;
  - NOP_INST=32'h0;
  - PC_INC=32'd4.
- One sub-module, fetch_hold_buf: a 1-entry {inst,pc} register with load, clear, full flag, Clk and Clrn.

Test Plan:
1. Reset release with zero-wait memory (ready tied to req) and stall=0 → imem_addr 0,4,8 on consecutive cycles; if_pc 0,4,8 one cycle later; if_pc4 = if_pc+4.
2. Stall asserted for 3 cycles while the response for 0x10 arrives → state HOLD, imem_req=0, if_pc stays 0x0C. After stall drops, if_pc=0x10 and fetch resumes at 0x14.
3. Memory latency 3, redirect to 0x103 in the cycle after the request for 0x20 → req stays at 0x20 until ready; the response is discarded (if_valid=0). The next request is 0x100.
4. Redirect together with ready in FETCH → response dropped, next imem_addr equals the target; redirect plus stall both high still flushes if_valid.
5. RESET_PC=32'hFFFF_FFFC → addresses FFFF_FFFC then 0; if_pc4 of the first instruction is 0.
6. Clrn pulsed low during HOLD → all outputs 0 immediately; fetch restarts at RESET_PC. With FETCH_PERF_EN defined, both counters read 0 and perf_fetched counts scenario 1 correctly.
